// File: rtl/led_scroll_gen_pkg.sv
// Shared types and constants for the LED scroll engine.
// Holds the state enum, the blank segment pattern and the default step divider.
package led_scroll_pkg;

    localparam logic [7:0] BLANK        = 8'hFF;
    localparam int         DEFAULT_DVSR = 25_000_000;
    localparam int         N_DIGITS     = 4;

    typedef enum logic [1:0] {
        EMPTY,
        STATIC,
        SCROLL,
        PAUSE
    } scroll_state_t;

    // Mode implied by a message length and the scroll enable.
    function automatic scroll_state_t state_for(input int unsigned len_v, input logic en_v);
        if (len_v == 0)
            return EMPTY;
        else if (len_v <= N_DIGITS)
            return STATIC;
        else if (en_v)
            return SCROLL;
        else
            return PAUSE;
    endfunction

endpackage

// File: rtl/led_scroll_gen_if.sv
// Control/data bundle between a message source and led_scroll_gen.
// The master writes patterns and steers scrolling; the slave drives the four digits.
interface led_scroll_gen_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [7:0]        wr_data;
    logic              clr;
    logic              en;
    logic              dir;
    logic [7:0]        in3;
    logic [7:0]        in2;
    logic [7:0]        in1;
    logic [7:0]        in0;
    logic [ADDR_W:0]   len;
    logic              full;
    logic              step;

    modport master (
        output wr_en, wr_data, clr, en, dir,
        input  in3, in2, in1, in0, len, full, step
    );

    modport slave (
        input  wr_en, wr_data, clr, en, dir,
        output in3, in2, in1, in0, len, full, step
    );
endinterface

// File: rtl/led_scroll_gen_scroll_tick.sv
// Mod-DVSR tick counter for the scroll engine: counts while enabled,
// holds while disabled, and raises step during the last count of each period.
import led_scroll_pkg::*;

module scroll_tick #(
    parameter int DVSR = DEFAULT_DVSR
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic step
);
    localparam int              CW   = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DVSR - 1);

    logic [CW-1:0] cnt_reg;

    // Clear wins over a pending step so a cleared message never advances.
    assign step = en && !clr && (cnt_reg == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_reg <= '0;
        else if (clr)
            cnt_reg <= '0;
        else if (en)
            cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
    end

endmodule

// File: rtl/led_scroll_gen.sv
// Message buffer and four-digit scroll window feeding disp_mux in3..in0.
// Define SCROLL_GAP_EN to insert one blank digit between message end and restart.
import led_scroll_pkg::*;

module led_scroll_gen #(
    parameter int ADDR_W = 4,
    parameter int DVSR   = DEFAULT_DVSR
) (
    input  logic             clk,
    input  logic             reset_n,
    led_scroll_gen_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LW    = ADDR_W + 1;
    localparam int IW    = ADDR_W + 2;

    logic [7:0]                 mem_reg [DEPTH];
    scroll_state_t              state_reg, state_next;
    logic [LW-1:0]              len_reg, len_next;
    logic [LW-1:0]              ptr_reg, ptr_next;
    logic                       full_reg;
    logic [N_DIGITS-1:0][7:0]   win_reg, win_next;

    logic                       wr_ok;
    logic                       step;
    logic                       tick_en;
    logic                       tick_clr;
    logic                       rotating;
    logic [LW-1:0]              span;
    logic [LW-1:0]              vis_lim;

`ifdef SCROLL_GAP_EN
    // Virtual index len is the blank gap; everything below it is message.
    assign span    = len_reg + LW'(1);
    assign vis_lim = len_reg;
`else
    assign span    = len_reg;
    assign vis_lim = LW'(DEPTH);
`endif

    assign rotating = (state_reg == SCROLL) || (state_reg == PAUSE);
    assign tick_en  = (state_reg == SCROLL);
    assign tick_clr = bus.clr || !rotating;

    scroll_tick #(.DVSR(DVSR)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (tick_en),
        .clr     (tick_clr),
        .step    (step)
    );

    always_comb begin
        wr_ok    = bus.wr_en && !full_reg && !bus.clr;
        len_next = len_reg;
        if (bus.clr)
            len_next = '0;
        else if (wr_ok)
            len_next = len_reg + LW'(1);

        state_next = state_for(32'(len_next), bus.en);

        // Wrap uses the current span, so a same-cycle write does not shift it.
        ptr_next = ptr_reg;
        if (tick_clr)
            ptr_next = '0;
        else if (step) begin
            if (!bus.dir)
                ptr_next = (ptr_reg == span - LW'(1)) ? '0 : ptr_reg + LW'(1);
            else
                ptr_next = (ptr_reg == '0) ? span - LW'(1) : ptr_reg - LW'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            logic [IW-1:0] idx_raw;
            logic [IW-1:0] idx;
            logic [7:0]    digit_next;

            // ptr < span and gi < span, so one conditional subtract is the modulo.
            assign idx_raw = IW'(ptr_reg) + IW'(gi);
            assign idx     = (idx_raw >= IW'(span)) ? idx_raw - IW'(span) : idx_raw;

            always_comb begin
                digit_next = BLANK;
                case (state_reg)
                    STATIC: begin
                        if (LW'(gi) < len_reg)
                            digit_next = mem_reg[gi];
                    end
                    SCROLL, PAUSE: begin
                        if (idx < IW'(vis_lim))
                            digit_next = mem_reg[idx[ADDR_W-1:0]];
                    end
                    default: digit_next = BLANK;
                endcase
            end

            assign win_next[gi] = digit_next;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= EMPTY;
            len_reg   <= '0;
            full_reg  <= 1'b0;
            ptr_reg   <= '0;
            win_reg   <= {N_DIGITS{BLANK}};
        end else begin
            state_reg <= state_next;
            len_reg   <= len_next;
            full_reg  <= (len_next == LW'(DEPTH));
            ptr_reg   <= ptr_next;
            win_reg   <= win_next;
        end
    end

    // Pattern storage survives reset and clr; only len decides what is visible.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem_reg[len_reg[ADDR_W-1:0]] <= bus.wr_data;
    end

    assign bus.in3  = win_reg[0];
    assign bus.in2  = win_reg[1];
    assign bus.in1  = win_reg[2];
    assign bus.in0  = win_reg[3];
    assign bus.len  = len_reg;
    assign bus.full = full_reg;
    assign bus.step = step;

endmodule

// File: tb/tb_led_scroll_gen.sv
// Bench for led_scroll_gen with DVSR=4: vector table, hand-written scroll/pause/reset
// sequences and random traffic, all compared each cycle against a queue-based message model.
module tb_led_scroll_gen;
    import led_scroll_pkg::*;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int DVSR   = 4;
`ifdef SCROLL_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    led_scroll_gen_if #(.ADDR_W(ADDR_W)) bus ();

    led_scroll_gen #(.ADDR_W(ADDR_W), .DVSR(DVSR)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   step_count = 0;
    logic saw_step   = 1'b0;

    // Reference model: the message as a queue, a window offset and a step phase.
    logic [7:0]  m_msg[$];
    int          m_ptr;
    int          m_phase;
    bit          m_run;
    logic [31:0] m_win;

    typedef struct {
        logic        wr;
        logic [7:0]  data;
        logic        clr;
        logic        en;
        logic        dir;
        int          idle;
        logic        chk_win;
        logic [31:0] win;
        int          len;
        int          steps;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic wr, input logic [7:0] data, input logic clr,
                                input logic en, input logic dir, input int idle,
                                input logic chk_win, input logic [31:0] win,
                                input int len, input int steps);
        vec_t v;
        v.wr = wr; v.data = data; v.clr = clr; v.en = en; v.dir = dir; v.idle = idle;
        v.chk_win = chk_win; v.win = win; v.len = len; v.steps = steps;
        vecs.push_back(v);
    endfunction

    function automatic logic [31:0] view();
        logic [31:0] w;
        int n, span, i;
        n    = m_msg.size();
        span = n + GAP;
        w    = '1;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] d;
            d = 8'hFF;
            if (n > 0 && n <= 4) begin
                if (k < n) d = m_msg[k];
            end else if (n > 4) begin
                i = (m_ptr + k) % span;
                if (i < n) d = m_msg[i];
            end
            w[31-8*k -: 8] = d;
        end
        return w;
    endfunction

    function automatic void model_reset();
        m_msg.delete();
        m_ptr   = 0;
        m_phase = 0;
        m_run   = 1'b0;
        m_win   = 32'hFFFF_FFFF;
    endfunction

    function automatic void model_edge();
        int  n, span;
        bit  fire;
        if (!reset_n) begin
            model_reset();
            return;
        end
        n     = m_msg.size();
        span  = n + GAP;
        fire  = m_run && (m_phase == DVSR - 1) && !bus.clr;
        m_win = view();
        if (bus.clr) begin
            m_msg.delete();
            m_ptr   = 0;
            m_phase = 0;
        end else begin
            if (n > 4) begin
                if (m_run) begin
                    if (fire) begin
                        m_phase = 0;
                        m_ptr   = bus.dir ? (m_ptr + span - 1) % span : (m_ptr + 1) % span;
                    end else begin
                        m_phase++;
                    end
                end
            end else begin
                m_ptr   = 0;
                m_phase = 0;
            end
            if (bus.wr_en && n < DEPTH) m_msg.push_back(bus.wr_data);
        end
        m_run = (m_msg.size() > 4) && bus.en;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] win_now();
        return {bus.in3, bus.in2, bus.in1, bus.in0};
    endfunction

    task automatic drive(input logic wr, input logic [7:0] data, input logic clr,
                         input logic en, input logic dir);
        bus.wr_en   = wr;
        bus.wr_data = data;
        bus.clr     = clr;
        bus.en      = en;
        bus.dir     = dir;
    endtask

    // Called just after a falling edge with this cycle's inputs already driven.
    task automatic cycle();
        logic pred;
        #1;
        pred = m_run && (m_phase == DVSR - 1) && !bus.clr;
        chk("model_win",  win_now(), m_win);
        chk("model_len",  32'(bus.len), m_msg.size());
        chk("model_full", 32'(bus.full), 32'(m_msg.size() == DEPTH));
        chk("model_step", 32'(bus.step), 32'(pred));
        saw_step = bus.step;
        if (bus.step) step_count++;
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
    endtask

    task automatic wait_steps(input int n, input string tag);
        int got    = 0;
        int prev   = -1;
        int budget = n * DVSR * 2 + 8;
        while (got < n && budget > 0) begin
            cycle();
            budget--;
            if (saw_step) begin
                if (prev >= 0) chk({tag, "_period"}, cyc - prev, DVSR);
                prev = cyc;
                got++;
            end
        end
        if (got < n) chk({tag, "_timeout"}, got, n);
    endtask

    task automatic load(input logic [7:0] p[6], input logic en, input logic dir);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, p[i], 1'b0, en, dir);
            cycle();
        end
        drive(1'b0, 8'h00, 1'b0, en, dir);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [7:0] msg6 [6];
        logic       en_r, dir_r;
        int         s0, lat;
        bit         found;

        msg6 = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92};

        // Static, full and clear behaviour as a vector table.
        add(0, 8'h00, 1, 1, 0, 1,  1, 32'hFFFF_FFFF, 0, 0);
        add(1, 8'hC0, 0, 1, 0, 0,  1, 32'hFFFF_FFFF, 1, 0);
        add(1, 8'hF9, 0, 1, 0, 0,  1, 32'hC0FF_FFFF, 2, 0);
        add(1, 8'hA4, 0, 1, 0, 1,  1, 32'hC0F9_A4FF, 3, 0);
        add(0, 8'h00, 0, 1, 0, 20, 1, 32'hC0F9_A4FF, 3, 0);
        add(0, 8'h00, 1, 0, 0, 1,  1, 32'hFFFF_FFFF, 0, 0);
        for (int i = 0; i < DEPTH; i++)
            add(1, 8'(8'h10 + i), 0, 0, 0, (i == DEPTH - 1) ? 1 : 0,
                (i == DEPTH - 1), 32'h1011_1213, i + 1, 0);
        add(1, 8'hEE, 0, 0, 0, 1,  1, 32'h1011_1213, 16, 0);
        add(1, 8'h55, 1, 0, 0, 0,  0, 32'h0000_0000, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0,  1, 32'hFFFF_FFFF, 0, 0);

        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        model_reset();
        #1 reset_n = 1'b0;
        #1;
        chk("reset_win",  win_now(), 32'hFFFF_FFFF);
        chk("reset_len",  32'(bus.len), 0);
        chk("reset_full", 32'(bus.full), 0);
        chk("reset_step", 32'(bus.step), 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            s0 = step_count;
            drive(vecs[i].wr, vecs[i].data, vecs[i].clr, vecs[i].en, vecs[i].dir);
            cycle();
            drive(1'b0, 8'h00, 1'b0, vecs[i].en, vecs[i].dir);
            repeat (vecs[i].idle) cycle();
            if (vecs[i].chk_win) chk($sformatf("vec%0d_win", i), win_now(), vecs[i].win);
            chk($sformatf("vec%0d_len", i),   32'(bus.len), vecs[i].len);
            chk($sformatf("vec%0d_full", i),  32'(bus.full), 32'(vecs[i].len == DEPTH));
            chk($sformatf("vec%0d_steps", i), step_count - s0, vecs[i].steps);
        end

        // Scroll left across a six-pattern message.
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        cycle();
        load(msg6, 1'b1, 1'b0);
        wait_steps(4, "left4");
        cycle();
`ifdef SCROLL_GAP_EN
        chk("left4_win", win_now(), 32'h9992_FFC0);
`else
        chk("left4_win", win_now(), 32'h9992_C0F9);
`endif
        wait_steps(2, "left6");
        cycle();
`ifdef SCROLL_GAP_EN
        chk("left6_win", win_now(), 32'hFFC0_F9A4);
`else
        chk("left6_win", win_now(), 32'hC0F9_A4B0);
`endif

        // Scroll right from ptr=0, then pause and resume mid-period.
        drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cycle();
        load(msg6, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        wait_steps(1, "right1");
        cycle();
`ifdef SCROLL_GAP_EN
        chk("right1_win", win_now(), 32'hFFC0_F9A4);
`else
        chk("right1_win", win_now(), 32'h92C0_F9A4);
`endif
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        s0 = step_count;
        repeat (10) cycle();
        chk("pause_steps", step_count - s0, 0);
`ifdef SCROLL_GAP_EN
        chk("pause_win", win_now(), 32'hFFC0_F9A4);
`else
        chk("pause_win", win_now(), 32'h92C0_F9A4);
`endif
        // Two counts were spent before the pause; two remain after the state re-registers.
        drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        lat   = 0;
        found = 1'b0;
        while (!found && lat < 10) begin
            cycle();
            lat++;
            if (saw_step) found = 1'b1;
        end
        chk("resume_latency", lat, 3);

        // Random traffic against the model.
        en_r  = 1'b1;
        dir_r = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) en_r  = ~en_r;
            if ($urandom_range(0, 59) == 0) dir_r = ~dir_r;
            drive($urandom_range(0, 11) == 0, 8'($urandom), $urandom_range(0, 149) == 0,
                  en_r, dir_r);
            cycle();
        end

        // Reset asserted mid-scroll blanks the outputs at once.
        drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        cycle();
        load(msg6, 1'b1, 1'b0);
        repeat (6) cycle();
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("midreset_win",  win_now(), 32'hFFFF_FFFF);
        chk("midreset_len",  32'(bus.len), 0);
        chk("midreset_full", 32'(bus.full), 0);
        chk("midreset_step", 32'(bus.step), 0);
        @(negedge clk);
        repeat (2) cycle();
        reset_n = 1'b1;
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
